path_delay_meter: RTL and testbench

- On-chip launch/capture harness that measures, in whole clock periods, the propagation delay of an external combinational or flop path built from the team's standard cells.
- Drives a transition into the path input (launch) and detects when the path output (sense) reaches the expected level.
- Reports the cycle count, or a timeout if the level is never reached.
- Sits beside the synthesized design under timing analysis and is driven by a simple start/done controller.

---
 rtl/path_delay_meter_pkg.sv | 15 +
 rtl/path_delay_meter_sense_sync.sv | 20 ++
 rtl/path_delay_meter.sv | 136 +++++++++++++
 tb/tb_path_delay_meter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/path_delay_meter_pkg.sv
// Shared encodings for the path delay meter: FSM states and the saturated
// result value reported on timeout.
package path_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Sliced down to CNT_W by the user; wide enough for any sane counter.
  localparam logic [63:0] ALL_ONES = '1;

endpackage

// File: rtl/path_delay_meter_sense_sync.sv
// Flop-chain synchronizer for the path sense input, cleared to 0 on reset.
module sense_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launch/capture harness: toggles launch, counts clocks until the synchronized
// sense output reaches the expected level, reports delay or timeout.
module path_delay_meter
  import path_meter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             expect_inv,
  input  logic             sense,
  output logic             launch,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             rise,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SYNC_LAT = CNT_W'(SYNC_STAGES);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             inv_q;
  logic             sense_s;
  logic             match;
  logic             acc, tog, inc, hit, to_hit;

  sense_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (C),
    .rst_n (R),
    .d     (sense),
    .q     (sense_s)
  );

  // In WAIT the launch register already holds the new value, so one compare
  // serves both the pre-launch check and the post-launch capture.
  assign match = (sense_s == (launch ^ inv_q));

  always_ff @(posedge C or negedge R) begin
    if (!R) state <= IDLE;
    else    state <= nxt;
  end

  always_comb begin
    nxt    = state;
    acc    = 1'b0;
    tog    = 1'b0;
    inc    = 1'b0;
    hit    = 1'b0;
    to_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc = 1'b1;
          nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (match) begin
          tog = 1'b1;
          nxt = WAIT;
        end else if (cnt == CNT_LAST) begin
          to_hit = 1'b1;
          nxt    = DONE;
        end else begin
          inc = 1'b1;
        end
      end
      WAIT: begin
        if (match) begin
          hit = 1'b1;
          nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          to_hit = 1'b1;
          nxt    = DONE;
        end else begin
          inc = 1'b1;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Counter never passes CNT_LAST, so it cannot wrap for legal TIMEOUT.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      cnt   <= '0;
      inv_q <= 1'b0;
    end else begin
      if (acc) begin
        cnt   <= '0;
        inv_q <= expect_inv;
      end else if (tog) begin
        cnt <= '0;
      end else if (inc) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // launch survives across measurements so edges alternate rise/fall.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      launch <= 1'b0;
      rise   <= 1'b0;
    end else if (tog) begin
      launch <= ~launch;
      rise   <= ~launch;
    end
  end

  // Subtract the synchronizer latency so a bare wire reads as zero.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      timeout <= 1'b0;
      cycles  <= '0;
    end else begin
      if (acc) timeout <= 1'b0;
      if (hit) cycles <= (cnt >= SYNC_LAT) ? (cnt - SYNC_LAT) : '0;
      if (to_hit) begin
        timeout <= 1'b1;
        cycles  <= ALL_ONES[CNT_W-1:0];
      end
    end
  end

  assign busy = (state == SETTLE) || (state == WAIT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_path_delay_meter.sv
// Bench for path_delay_meter: table of measurement scenarios against several
// sense sources, scoreboard of expected results checked on each done pulse.
module tb_path_delay_meter;

  localparam int CNT_W = 8;

  // sense sources
  localparam int M_LOOP = 0;
  localparam int M_CH5  = 1;
  localparam int M_INV3 = 2;
  localparam int M_TIE0 = 3;

  typedef struct {
    int   mode;
    logic inv;
    int   cyc;
    logic to;
    logic rise;
    logic launch;
    int   lat;    // posedges from launch change to done; -1 = no launch
  } row_t;

  logic             C = 1'b0;
  logic             R = 1'b0;
  logic             start = 1'b0;
  logic             expect_inv = 1'b0;
  logic             sense;
  logic             launch, busy, done, timeout, rise;
  logic [CNT_W-1:0] cycles;

  int   mode = M_LOOP;
  logic [4:0] ch5  = '0;
  logic [2:0] inv3 = '0;

  int   total = 0;
  int   bad   = 0;
  int   ndone = 0;
  logic done_d = 1'b0;
  logic chk_en = 1'b0;
  row_t sb[$];
  row_t rows[10];

  path_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(200), .SYNC_STAGES(2)) dut (
    .C          (C),
    .R          (R),
    .start      (start),
    .expect_inv (expect_inv),
    .sense      (sense),
    .launch     (launch),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .rise       (rise),
    .cycles     (cycles)
  );

  always #5 C = ~C;

  always @(posedge C) begin
    ch5  <= {ch5[3:0], launch};
    inv3 <= {inv3[1:0], ~launch};
  end

  always_comb begin
    case (mode)
      M_LOOP:  sense = launch;
      M_CH5:   sense = ch5[4];
      M_INV3:  sense = inv3[2];
      default: sense = 1'b0;
    endcase
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge C) begin
    if (chk_en && done) begin
      ndone++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        row_t e;
        e = sb.pop_front();
        check("cycles", int'(cycles), e.cyc);
        check("timeout", int'(timeout), int'(e.to));
        check("rise", int'(rise), int'(e.rise));
        check("launch", int'(launch), int'(e.launch));
        check("busy_at_done", int'(busy), 0);
      end
      if (done_d) check("done_one_cycle", 1, 0);
    end
    done_d = done;
  end

  task automatic run_row(input row_t r);
    logic l0;
    logic launched;
    logic got;
    int   lat;
    mode       = r.mode;
    expect_inv = r.inv;
    sb.push_back(r);
    @(negedge C); start = 1'b1;
    @(negedge C); start = 1'b0;
    l0 = launch;
    launched = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int n = 0; n < 600 && !got; n++) begin
      @(negedge C);
      if (launched) lat++;
      if (launch != l0) launched = 1'b1;
      if (done) got = 1'b1;
    end
    if (!got) check("done_seen", 0, 1);
    check("latency", launched ? lat : -1, r.lat);
    repeat (10) @(negedge C);
  endtask

  initial begin
    rows[0] = '{M_LOOP, 1'b0, 0,   1'b0, 1'b1, 1'b1, 3};
    rows[1] = '{M_LOOP, 1'b0, 0,   1'b0, 1'b0, 1'b0, 3};
    rows[2] = '{M_CH5,  1'b0, 5,   1'b0, 1'b1, 1'b1, 8};
    rows[3] = '{M_CH5,  1'b0, 5,   1'b0, 1'b0, 1'b0, 8};
    rows[4] = '{M_INV3, 1'b1, 3,   1'b0, 1'b1, 1'b1, 6};
    rows[5] = '{M_INV3, 1'b1, 3,   1'b0, 1'b0, 1'b0, 6};
    rows[6] = '{M_TIE0, 1'b0, 255, 1'b1, 1'b1, 1'b1, 200};
    rows[7] = '{M_TIE0, 1'b0, 255, 1'b1, 1'b1, 1'b1, -1};
    rows[8] = '{M_LOOP, 1'b0, 0,   1'b0, 1'b0, 1'b0, 3};
    rows[9] = '{M_TIE0, 1'b1, 255, 1'b1, 1'b0, 1'b0, -1};

    repeat (4) @(negedge C);
    check("rst_launch", int'(launch), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_rise", int'(rise), 0);
    check("rst_cycles", int'(cycles), 0);
    R = 1'b1;
    chk_en = 1'b1;
    repeat (10) @(negedge C);

    for (int i = 0; i < 10; i++) run_row(rows[i]);

    // Abort mid-WAIT with an asynchronous reset: no done may follow.
    mode = M_CH5;
    expect_inv = 1'b0;
    @(negedge C); start = 1'b1;
    @(negedge C); start = 1'b0;
    repeat (4) @(negedge C);
    check("abort_launch_before", int'(launch), 1);
    #2 R = 1'b0;
    #1;
    check("abort_launch", int'(launch), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (3) @(negedge C);
    R = 1'b1;
    repeat (10) @(negedge C);

    run_row('{M_LOOP, 1'b0, 0, 1'b0, 1'b1, 1'b1, 3});

    // Extra start pulses while busy must not queue a second measurement.
    begin
      int nd0;
      nd0 = ndone;
      mode = M_CH5;
      sb.push_back('{M_CH5, 1'b0, 5, 1'b0, 1'b0, 1'b0, 8});
      @(negedge C); start = 1'b1;
      @(negedge C); start = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge C);
        start = (i == 2 || i == 4 || i == 6);
      end
      check("dones_with_busy_starts", ndone - nd0, 1);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
